// File: rtl/instruction_memory_loader.sv
// Program loader for the 16-bit fetch path: streams words into a 32-entry store
// over valid/ready and raises fetch_enable once the requested program is in place.
module instruction_memory_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fetch_enable,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   len_clamped;

  function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  assign len_clamped  = clamp_len(load_len);
  assign rd_data      = mem[rd_addr];
  assign fetch_enable = done;

  // Status outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      remaining  <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            wr_ptr     <= '0;
            remaining  <= len_clamped;
            word_count <= '0;
            if (len_clamped != '0) begin
              state    <= LOAD;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              done     <= 1'b0;
            end else begin
              state    <= DONE;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + 1'b1;
            remaining   <= remaining - ONE;
            word_count  <= word_count + ONE;
            if (remaining == ONE) begin
              state    <= DONE;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: load, stall, clamp, reload,
// mid-load reset and zero-length start, each with hand-computed expectations.
module tb_instruction_memory_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  load_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        fetch_enable;
  logic [5:0]  word_count;

  int tests  = 0;
  int failed = 0;

  instruction_memory_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_len     (load_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .fetch_enable (fetch_enable),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] e, input string tag);
    rd_addr = a;
    #1;
    check(tag, 32'(rd_data), 32'(e));
  endtask

  task automatic begin_load(input logic [5:0] len);
    start    = 1'b1;
    load_len = len;
    tick();
    start    = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] w1 [4];
  logic [5:0]  pat;
  int          ready_cnt;
  int          k;

  initial begin
    w1[0] = 16'h1111; w1[1] = 16'h2222; w1[2] = 16'h3333; w1[3] = 16'h4444;
    reset = 1'b0; start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0; rd_addr = '0;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fetch_enable", 32'(fetch_enable), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    rd(5'd0, 16'h0000, "rst_rd0");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // Basic 4-word load with in_valid held high
    begin_load(6'd4);
    check("t1_busy", 32'(busy), 32'd1);
    ready_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w1[i];
      rd_addr  = 5'(i);
      #1;
      if (i == 0) check("t1_same_cycle_old", 32'(rd_data), 32'd0);
      if (in_ready) ready_cnt++;
      tick();
    end
    in_valid = 1'b0;
    if (in_ready) ready_cnt++;
    check("t1_ready_cycles", 32'(ready_cnt), 32'd4);
    check("t1_done", 32'(done), 32'd1);
    check("t1_fetch_enable", 32'(fetch_enable), 32'd1);
    check("t1_word_count", 32'(word_count), 32'd4);
    for (int i = 0; i < 4; i++) rd(5'(i), w1[i], "t1_rd");
    rd(5'd4, 16'h0000, "t1_rd4");

    // Stalled source: valid pattern 1,0,0,1,0,1
    pat = 6'b101001;
    begin_load(6'd3);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      in_data  = 16'h0A01 + 16'(k);
      #1;
      check("t2_busy", 32'(busy), 32'd1);
      tick();
      if (pat[i]) k++;
    end
    in_valid = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    check("t2_word_count", 32'(word_count), 32'd3);
    rd(5'd0, 16'h0A01, "t2_rd0");
    rd(5'd1, 16'h0A02, "t2_rd1");
    rd(5'd2, 16'h0A03, "t2_rd2");
    rd(5'd3, 16'h4444, "t2_rd3_kept");

    // load_len=40 clamps to 32
    begin_load(6'd40);
    for (int i = 0; i < 32; i++) feed(16'hC000 + 16'(i));
    check("t3_done", 32'(done), 32'd1);
    check("t3_word_count", 32'(word_count), 32'd32);
    feed(16'hFFFF);
    check("t3_in_ready_after", 32'(in_ready), 32'd0);
    rd(5'd0, 16'hC000, "t3_rd0_no_wrap");
    rd(5'd16, 16'hC010, "t3_rd16");
    rd(5'd31, 16'hC01F, "t3_rd31");

    // Reload from DONE
    start    = 1'b1;
    load_len = 6'd2;
    #1;
    check("t4_fe_before", 32'(fetch_enable), 32'd1);
    tick();
    start = 1'b0;
    check("t4_fe_drop", 32'(fetch_enable), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    feed(16'hAAAA);
    feed(16'hBBBB);
    check("t4_done", 32'(done), 32'd1);
    check("t4_word_count", 32'(word_count), 32'd2);
    rd(5'd0, 16'hAAAA, "t4_rd0");
    rd(5'd1, 16'hBBBB, "t4_rd1");
    rd(5'd2, 16'hC002, "t4_rd2_kept");
    rd(5'd31, 16'hC01F, "t4_rd31_kept");

    // Reset after 2 of 5 words
    begin_load(6'd5);
    feed(16'h1234);
    feed(16'h5678);
    in_valid = 1'b1;
    in_data  = 16'h9ABC;
    check("t5_word_count_mid", 32'(word_count), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_word_count", 32'(word_count), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    rd(5'd0, 16'h0000, "t5_rd0");
    rd(5'd1, 16'h0000, "t5_rd1");
    rd(5'd31, 16'h0000, "t5_rd31");
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) tick();
    check("t5_post_in_ready", 32'(in_ready), 32'd0);
    check("t5_post_busy", 32'(busy), 32'd0);
    check("t5_post_done", 32'(done), 32'd0);
    rd(5'd0, 16'h0000, "t5_post_rd0");

    // Zero-length start in IDLE, then from DONE
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    start    = 1'b1;
    load_len = 6'd0;
    #1;
    check("t6_in_ready_pre", 32'(in_ready), 32'd0);
    tick();
    start = 1'b0;
    check("t6_done", 32'(done), 32'd1);
    check("t6_word_count", 32'(word_count), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    rd(5'd0, 16'h0000, "t6_rd0");
    begin_load(6'd1);
    feed(16'h7777);
    check("t6_one_word_count", 32'(word_count), 32'd1);
    begin_load(6'd0);
    check("t6_done_again", 32'(done), 32'd1);
    check("t6_wc_zero", 32'(word_count), 32'd0);
    rd(5'd0, 16'h7777, "t6_rd0_unchanged");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
- Write-side counterpart to the 16-bit instruction fetch path.
- Accepts a program as a stream of 16-bit words over a valid/ready handshake and writes them sequentially into a 32-entry x 16-bit instruction store.
- Exposes a combinational read port for the fetch stage, indexed by PC[5:1].
- Asserts fetch_enable only once a complete program is loaded, so the program counter can be held until then.

Parameters:
- DATA_WIDTH, 16, instruction word width.
- DEPTH, 32, number of instruction words.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load.
- load_len  input  6  number of words to load, 0..32; values above 32 are clamped to 32.
- in_valid  input  1  in_data holds a word offered for writing.
- in_data  input  16  instruction word.
- in_ready  output  1  loader accepts a word this cycle.
- rd_addr  input  5  fetch read address.
- rd_data  output  16  mem[rd_addr], combinational.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- fetch_enable  output  1  equal to done; gates the program counter.
- word_count  output  6  words accepted in the current or last load.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; wr_ptr = 0; remaining = 0; word_count = 0.
  - All 32 memory entries cleared to 0.
  - in_ready, busy, done and fetch_enable are 0; rd_data reads 0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready = 0; in_valid is ignored.
  - start with clamped load_len > 0 -> LOAD next cycle. Set wr_ptr = 0, remaining = clamped load_len, word_count = 0.
  - start with load_len = 0 -> DONE next cycle. Set word_count = 0; memory is unchanged.
- LOAD:
  - busy = 1 and in_ready = 1 in every cycle of this state.
  - A word transfers when in_valid and in_ready are both high at a rising edge. On that edge: mem[wr_ptr] <= in_data; wr_ptr increments; remaining decrements; word_count increments.
  - When the accepted word makes remaining 0, the next state is DONE and in_ready is 0 from the following cycle on. A stalled source (in_valid low) holds state indefinitely; there is no timeout.
  - start during LOAD is ignored.
  - wr_ptr wraps from 31 to 0 arithmetically. This can never occur within a single load, because of the clamp.
- DONE:
  - done = 1, fetch_enable = 1, in_ready = 0; in_valid is ignored.
  - Memory contents and word_count hold.
  - start -> LOAD (or back to DONE if load_len = 0), with the same initialisation as from IDLE. fetch_enable falls in the cycle after start is sampled.
- Read port:
  - rd_data = mem[rd_addr], combinational, valid in every state.
  - A word written at edge N is visible on rd_data after edge N. Same-cycle read of the address being written returns the old value.
- Entries beyond load_len keep their previous contents; a load does not clear them.
- Reset asserted mid-LOAD aborts the load immediately: memory is cleared and the loader returns to IDLE. On release, the loader waits for a new start.
- word_count width covers 0..32 without overflow.

Test Plan:
- Reset, then start with load_len=4 and words 16'h1111, 16'h2222, 16'h3333, 16'h4444 streamed with in_valid held high -> in_ready high for exactly 4 cycles. done=1 on the cycle after the 4th accept; word_count=4; rd_addr 0..3 return the words in order; rd_addr=4 returns 0.
- load_len=3 with in_valid toggled 1,0,0,1,0,1 -> only the valid cycles write. The loader stays in LOAD through the gaps; done asserts after the 3rd accept; mem[0..2] are correct.
- load_len=40 with 32 words offered -> clamped to 32; all entries written, including mem[31]; done=1; word_count=32; no write to entry 0 after the wrap.
- In DONE, start with load_len=2 and words 16'hAAAA, 16'hBBBB -> fetch_enable drops for the reload. mem[0..1] are updated; mem[2..] keep the prior load's values; done reasserts.
- Assert reset after 2 of 5 words are accepted -> outputs go to 0 asynchronously and all rd_data reads 0. After release the loader stays in IDLE, with in_ready=0, until start.
- start with load_len=0 in IDLE -> DONE on the next cycle; word_count=0; memory unchanged; no in_ready pulse.
